sid_write_arbiter: RTL

// Shares the single SID register write bus (WR/ADDR/DATAW) between two

---
 rtl/sid_bus_pkg.sv | 14 +
 rtl/sid_wr_fifo.sv | 59 +++++
 rtl/sid_write_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/sid_bus_pkg.sv
// Shared SID bus definitions: register widths, the queued write entry type,
// and the system-clock to SID-clock ratio.
package sid_bus_pkg;

  localparam int SID_ADDR_W = 5;
  localparam int SID_DATA_W = 8;
  localparam int SID_CLKDIV = 12;

  typedef struct packed {
    logic [SID_ADDR_W-1:0] addr;
    logic [SID_DATA_W-1:0] data;
  } sid_wr_t;

endpackage

// File: rtl/sid_wr_fifo.sv
// Synchronous FIFO holding pending SID register writes.
// Flush takes priority over push and pop; the caller never pushes when full or pops when empty.
module sid_wr_fifo #(
  parameter  int DEPTH   = 4,
  parameter  int WIDTH   = 13,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int LEVEL_W = PTR_W + 1
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               i_flush,
  input  logic               i_push,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_pop,
  output logic [WIDTH-1:0]   o_data,
  output logic               o_full,
  output logic               o_empty,
  output logic [LEVEL_W-1:0] o_level
);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [LEVEL_W-1:0] r_level;

  // NOTE: storage is deliberately not reset; only pointers and level define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge CLK) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + LEVEL_W'(1);
        2'b01:   r_level <= r_level - LEVEL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_level == LEVEL_W'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

endmodule

// File: rtl/sid_write_arbiter.sv
// Round-robin arbiter sharing the SID write bus between two requesters; writes
// are queued and issued at most one per CLKen so the SID never sees two in one cycle.
module sid_write_arbiter
  import sid_bus_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SID_ADDR_W,
  parameter int DATA_W = SID_DATA_W
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     CLKen,
  input  logic                     FLUSH,
  input  logic                     A_VALID,
  output logic                     A_READY,
  input  logic [ADDR_W-1:0]        A_ADDR,
  input  logic [DATA_W-1:0]        A_DATA,
  input  logic                     B_VALID,
  output logic                     B_READY,
  input  logic [ADDR_W-1:0]        B_ADDR,
  input  logic [DATA_W-1:0]        B_DATA,
  output logic                     WR,
  output logic [ADDR_W-1:0]        ADDR,
  output logic [DATA_W-1:0]        DATAW,
  output logic [$clog2(DEPTH):0]   LEVEL
);

  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic               r_rr_b;
  logic               r_wr;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_data;

  logic               w_full;
  logic               w_empty;
  logic               w_open;
  logic               w_grant_a;
  logic               w_grant_b;
  logic               w_push;
  logic               w_pop;
  logic               w_contended;
  logic [ENTRY_W-1:0] w_push_data;
  logic [ENTRY_W-1:0] w_head;

  // READY comes from the registered full flag: a pop in the same cycle does
  // not reopen the FIFO until the next CLK.
  assign w_open = !w_full && !FLUSH;

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    w_grant_a   = 1'b0;
    w_grant_b   = 1'b0;
    w_contended = A_VALID && B_VALID;
    if (w_open) begin
      if (w_contended) begin
        w_grant_a = !r_rr_b;
        w_grant_b = r_rr_b;
      end else begin
        w_grant_a = A_VALID;
        w_grant_b = B_VALID;
      end
    end
  end

  assign A_READY     = w_grant_a;
  assign B_READY     = w_grant_b;
  assign w_push      = w_grant_a || w_grant_b;
  assign w_push_data = w_grant_b ? {B_ADDR, B_DATA} : {A_ADDR, A_DATA};
  assign w_pop       = CLKen && !w_empty && !FLUSH;

  sid_wr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .i_flush (FLUSH),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (LEVEL)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_rr_b <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      if (w_open && w_contended) r_rr_b <= !r_rr_b;
      r_wr <= w_pop;
      if (w_pop) {r_addr, r_data} <= w_head;
    end
  end

  assign WR    = r_wr;
  assign ADDR  = r_addr;
  assign DATAW = r_data;

endmodule
